// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic oscillator mixer.
// Waveform modes, mixer FSM states and the volume scaling shift.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW,
    WAVE_SQUARE,
    WAVE_TRI,
    WAVE_PULSE25
  } wave_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

  localparam int VOL_SHIFT = 4;

endpackage

// File: rtl/voice_shaper.sv
// Combinational waveform generator and volume scaler for one voice.
// Turns a phase into a signed, volume-scaled sample.
import synth_pkg::*;

module voice_shaper #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 16
) (
  input  logic [PHASE_W-1:0]      phase,
  input  wave_t                   mode,
  input  logic [3:0]              vol,
  input  logic                    en,
  output logic signed [OUT_W-1:0] sample
);

  logic [OUT_W-1:0] top;
  logic [OUT_W-1:0] raw;
  logic [OUT_W-1:0] sgn;
  logic             msb;
  logic signed [OUT_W+4:0] sgn_x;
  logic signed [OUT_W+4:0] vol_x;
  logic signed [OUT_W+4:0] prod;
  logic signed [OUT_W+4:0] scaled;
  logic unused_bits;

  assign top = phase[PHASE_W-1 -: OUT_W];
  assign msb = top[OUT_W-1];

  // Raw unsigned waveform selected by mode.
  always_comb begin
    raw = '0;
    unique case (mode)
      WAVE_SAW:     raw = top;
      WAVE_SQUARE:  raw = {OUT_W{msb}};
      WAVE_TRI:     raw = msb ? ~(top << 1) : (top << 1);
      WAVE_PULSE25: raw = (top[OUT_W-1 -: 2] == 2'b00) ? '1 : '0;
      default:      raw = top;
    endcase
  end

  // Offset binary to two's complement is a flip of the sign bit.
  assign sgn   = raw ^ {1'b1, {(OUT_W-1){1'b0}}};
  assign sgn_x = {{5{sgn[OUT_W-1]}}, sgn};
  assign vol_x = {{(OUT_W+1){1'b0}}, vol};
  assign prod  = sgn_x * vol_x;
  assign scaled = prod >>> VOL_SHIFT;

  assign sample = en ? scaled[OUT_W-1:0] : '0;

  assign unused_bits = ^{phase, scaled[OUT_W+4:OUT_W]};

endmodule

// File: rtl/poly_osc_mixer.sv
// N-voice oscillator bank with a time-multiplexed saturating mixer.
// One shared shaper walks the voices; the sum leaves as offset PCM.
import synth_pkg::*;

module poly_osc_mixer #(
  parameter int VOICES  = 4,
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 16,
  parameter int DIV_W   = 8,
  localparam int IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   tick_div,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_voice,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic [1:0]         cfg_wave,
  input  logic [3:0]         cfg_vol,
  input  logic               cfg_en,
  output logic [OUT_W-1:0]   pcm,
  output logic               pcm_valid,
  output logic               clip,
  output logic               overrun
);

  localparam int ACC_W = OUT_W + $clog2(VOICES) + 1;

  logic [DIV_W-1:0]   cnt;
  logic               tick;
  logic               go;
  logic               cfg_ok;

  logic [PHASE_W-1:0] phase  [VOICES];
  logic [PHASE_W-1:0] sh_inc [VOICES];
  wave_t              wave   [VOICES];
  wave_t              sh_wave[VOICES];
  logic [3:0]         vol    [VOICES];
  logic [3:0]         sh_vol [VOICES];
  logic [VOICES-1:0]  en;
  logic [VOICES-1:0]  sh_en;

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   idx;
  logic               last;

  logic signed [OUT_W-1:0] scaled;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [OUT_W-1:0]        sat;
  logic                    ovf;

  assign tick   = (cnt >= tick_div);
  assign go     = tick && (state == S_IDLE);
  assign cfg_ok = cfg_we && (32'(cfg_voice) < VOICES);
  assign last   = (32'(idx) == VOICES - 1);

  voice_shaper #(
    .PHASE_W(PHASE_W),
    .OUT_W  (OUT_W)
  ) u_shaper (
    .phase (phase[idx]),
    .mode  (wave[idx]),
    .vol   (vol[idx]),
    .en    (en[idx]),
    .sample(scaled)
  );

  assign acc_sum = acc
    + {{(ACC_W-OUT_W){scaled[OUT_W-1]}}, scaled};

  // Accumulator fits OUT_W signed only if its top bits agree.
  assign ovf = !(&acc_sum[ACC_W-1:OUT_W-1]
              || ~|acc_sum[ACC_W-1:OUT_W-1]);

  assign sat = !ovf ? acc_sum[OUT_W-1:0]
             : acc_sum[ACC_W-1]
             ? {1'b1, {(OUT_W-1){1'b0}}}
             : {1'b0, {(OUT_W-1){1'b1}}};

  // Sample-tick divider, wraps on the tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= tick ? '0 : cnt + 1'b1;
  end

  // Voice state: shadow config load and tick-time phase/config update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        phase[i]   <= '0;
        sh_inc[i]  <= '0;
        wave[i]    <= WAVE_SAW;
        sh_wave[i] <= WAVE_SAW;
        vol[i]     <= '0;
        sh_vol[i]  <= '0;
      end
      en    <= '0;
      sh_en <= '0;
    end else begin
      if (go) begin
        for (int i = 0; i < VOICES; i++) begin
          phase[i] <= sh_en[i] ? phase[i] + sh_inc[i] : '0;
          wave[i]  <= sh_wave[i];
          vol[i]   <= sh_vol[i];
        end
        en <= sh_en;
      end
      if (cfg_ok) begin
        sh_inc[cfg_voice]  <= cfg_inc;
        sh_wave[cfg_voice] <= wave_t'(cfg_wave);
        sh_vol[cfg_voice]  <= cfg_vol;
        sh_en[cfg_voice]   <= cfg_en;
      end
    end
  end

  // Mixer FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Mixer FSM next state and valid strobe.
  always_comb begin
    state_nx  = state;
    pcm_valid = 1'b0;
    unique case (state)
      S_IDLE: if (tick) state_nx = S_ACC;
      S_ACC:  if (last) state_nx = S_OUT;
      S_OUT: begin
        pcm_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Accumulate one voice per cycle; register the saturated result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      acc     <= '0;
      pcm     <= {1'b1, {(OUT_W-1){1'b0}}};
      clip    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (tick && state != S_IDLE) overrun <= 1'b1;
      if (go) begin
        idx <= '0;
        acc <= '0;
      end
      if (state == S_ACC) begin
        acc <= acc_sum;
        idx <= idx + 1'b1;
        if (last) begin
          pcm  <= {~sat[OUT_W-1], sat[OUT_W-2:0]};
          clip <= ovf;
        end
      end
    end
  end

endmodule
